custom_mac_feeder: RTL
======================

CUSTOM_MAC_FEEDER -- requirements
Module: custom_mac_feeder

Interface
REQ-001 Parameters SHALL be none; all widths are fixed.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  one-cycle request to run one dot-product job.
REQ-005 num_beats  input  8  operand beats in the job, sampled when start is accepted.
REQ-006 act_in  input  32  four 8-bit activations; lane i is bits [8i+7:8i].
REQ-007 wgt_in  input  32  four 8-bit weights; lane i is bits [8i+7:8i].
REQ-008 in_valid  input  1  act_in/wgt_in hold a valid beat.
REQ-009 in_ready  output  1  block accepts a beat this cycle.
REQ-010 prod_1..prod_4  output  8 each  registered lane products that feed the four accumulator-stage inputs.
REQ-011 acc_en  output  1  accumulator enable, high for exactly one cycle per accepted beat.
REQ-012 acc_clr  output  1  active-high, one-cycle accumulator clear pulse at job start.
REQ-013 busy  output  1  high in any state other than IDLE.
REQ-014 done  output  1  one-cycle pulse when the job's final acc_en has been issued.

Function
REQ-015 The FSM SHALL have the states IDLE, CLEAR, STREAM, DRAIN and DONE.
REQ-016 IDLE: if start=1 and num_beats!=0, latch num_beats, zero the beat counter and go to CLEAR.
REQ-017 IDLE: if start=1 and num_beats=0, go to DONE. acc_clr SHALL pulse in that same cycle, no acc_en is issued, and the accumulator result is therefore 0.
REQ-018 CLEAR: acc_clr=1 for exactly one cycle, then go to STREAM. in_ready=0 in CLEAR.
REQ-019 STREAM: in_ready=1. A beat is accepted when in_valid and in_ready are both high.
REQ-020 On acceptance, prod_k SHALL be loaded with the low 8 bits of act lane (k-1) times wgt lane (k-1), unsigned. This is modulo-256 arithmetic, consistent with the 8-bit accumulator wrap.
REQ-021 acc_en SHALL be high in the cycle after each acceptance (1-cycle latency) and low otherwise.
REQ-022 prod_1..prod_4 SHALL hold their value when no beat is accepted.
REQ-023 The beat counter SHALL increment on each acceptance. On the acceptance that makes count equal the latched num_beats, in_ready drops the next cycle and the FSM goes to DRAIN.
REQ-024 DRAIN: one cycle; the last acc_en is asserted here. Then go to DONE.
REQ-025 DONE: done=1 for one cycle, then go to IDLE. in_ready=0.
REQ-026 start SHALL be ignored while busy=1. The latched num_beats SHALL NOT change mid-job.
REQ-027 in_valid gaps during STREAM SHALL stall the job with no timeout. acc_en stays low during a gap.
REQ-028 in_valid outside STREAM SHALL be ignored, and no beat is consumed.
REQ-029 num_beats=255 SHALL complete with exactly 255 acc_en pulses. The 8-bit counter never wraps.
REQ-030 At most one acc_clr SHALL be issued per job, and acc_clr and acc_en SHALL never be high in the same cycle.

Reset
REQ-031 rst=0 SHALL immediately force: state IDLE, counter 0, latched num_beats 0, prod_1..prod_4=0, acc_en=0, acc_clr=0, in_ready=0, busy=0, done=0.
REQ-032 rst asserted mid-job SHALL abort the job with no done pulse. Any in-flight acc_en is cancelled.
REQ-033 After rst deasserts, the block SHALL accept start on the first clock edge.

Verification
REQ-034 Basic job: start with num_beats=2, beats (act 1,2,3,4 / wgt 5,6,7,8) then (act 2,2,2,2 / wgt 3,3,3,3). Required response: acc_clr one cycle, then prod=5,12,21,32 with acc_en, then prod=6,6,6,6 with acc_en, then done. The downstream accumulator holds 94.
REQ-035 Wrap: act=16 and wgt=17 on all lanes, num_beats=1. Required response: prod_k=16 (272 mod 256) on every lane, one acc_en pulse, then done.
REQ-036 Backpressure: num_beats=3 with in_valid low for 4 cycles between beats 1 and 2. Required response: exactly 3 acc_en pulses, busy held throughout, done exactly 2 cycles after the 3rd acceptance.
REQ-037 Zero length: start with num_beats=0. Required response: acc_clr and done, no acc_en, in_ready never high.
REQ-038 Reset mid-op: rst low during STREAM after 1 of 4 beats. Required response: all outputs 0 while rst is low, no done pulse. A new start with num_beats=1 then completes normally.
REQ-039 Start while busy: start pulsed during STREAM with num_beats=9 while a 2-beat job runs. Required response: the job still ends after 2 beats and exactly one done pulse occurs.

Source files
------------

// File: rtl/custom_mac_feeder.sv
// Feeds four 8-bit lane products per accepted operand beat into a downstream
// accumulator, sequencing clear, enable and done around one dot-product job.
module custom_mac_feeder (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  num_beats,
  input  logic [31:0] act_in,
  input  logic [31:0] wgt_in,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [7:0]  prod_1,
  output logic [7:0]  prod_2,
  output logic [7:0]  prod_3,
  output logic [7:0]  prod_4,
  output logic        acc_en,
  output logic        acc_clr,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_STREAM,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] cnt_q;
  logic [7:0] nb_q;
  logic [7:0] prod_q [4];
  logic [7:0] prod_d [4];
  logic       accept;
  logic       launch;
  logic       last_beat;

  // Products are taken modulo 256 to match the 8-bit accumulator wrap.
  always_comb begin
    for (int unsigned i = 0; i < 4; i++) begin
      prod_d[i] = act_in[8*i +: 8] * wgt_in[8*i +: 8];
    end
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    acc_clr   = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    launch    = 1'b0;
    accept    = 1'b0;
    last_beat = 1'b0;
    case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          if (num_beats == '0) begin
            // Zero-length job clears in the request cycle; gated so reset keeps it low.
            acc_clr = rst;
            state_d = S_DONE;
          end else begin
            launch  = 1'b1;
            state_d = S_CLEAR;
          end
        end
      end
      S_CLEAR: begin
        acc_clr = 1'b1;
        state_d = S_STREAM;
      end
      S_STREAM: begin
        in_ready  = 1'b1;
        accept    = in_valid;
        last_beat = (cnt_q + 8'd1) == nb_q;
        if (accept && last_beat) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        state_d = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q  <= '0;
      nb_q   <= '0;
      acc_en <= 1'b0;
      for (int unsigned i = 0; i < 4; i++) begin
        prod_q[i] <= '0;
      end
    end else begin
      acc_en <= accept;
      if (launch) begin
        nb_q  <= num_beats;
        cnt_q <= '0;
      end
      if (accept) begin
        cnt_q <= cnt_q + 8'd1;
        for (int unsigned i = 0; i < 4; i++) begin
          prod_q[i] <= prod_d[i];
        end
      end
    end
  end

  assign prod_1 = prod_q[0];
  assign prod_2 = prod_q[1];
  assign prod_3 = prod_q[2];
  assign prod_4 = prod_q[3];

endmodule
